// File: rtl/sd_arbiter.sv
// sd_arbiter: round-robin arbiter sharing one sector channel to the IO controller between requesters A and B.
// Optional ISSUE-state watchdog abort is enabled by defining SD_ARBITER_TIMEOUT_EN.

module sd_arbiter #(
  parameter int TIMEOUT_W = 24
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [31:0] a_lba,
  input  logic        a_rd,
  input  logic        a_wr,
  output logic        a_ack,
  output logic        a_done,
  output logic        a_err,
  input  logic [7:0]  a_buff_din,
  output logic        a_buff_wr,
  input  logic [31:0] b_lba,
  input  logic        b_rd,
  input  logic        b_wr,
  output logic        b_ack,
  output logic        b_done,
  output logic        b_err,
  input  logic [7:0]  b_buff_din,
  output logic        b_buff_wr,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din
);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

  state_t      state_reg;
  logic        grant_reg;       // 0 = A, 1 = B
  logic        last_grant_reg;
  logic        ack_prev_reg;
  logic        a_ack_reg, b_ack_reg;
  logic        a_done_reg, b_done_reg;
  logic [31:0] sd_lba_reg;
  logic        sd_rd_reg, sd_wr_reg;

  logic pend_a, pend_b, pick_b, op_rd, ack_rise, ack_fall, in_xfer;

  always_comb begin
    pend_a   = a_rd | a_wr;
    pend_b   = b_rd | b_wr;
    // On a tie the requester that was not served last wins.
    pick_b   = pend_b & (~pend_a | ~last_grant_reg);
    op_rd    = pick_b ? b_rd : a_rd;
    ack_rise = sd_ack & ~ack_prev_reg;
    ack_fall = ~sd_ack & ack_prev_reg;
    in_xfer  = (state_reg == XFER);
  end

`ifdef SD_ARBITER_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  logic [TIMEOUT_W-1:0] cnt_reg;
  logic                 a_err_reg, b_err_reg;
  assign a_err = a_err_reg;
  assign b_err = b_err_reg;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_W > 0);
  assign a_err = 1'b0;
  assign b_err = 1'b0;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      ack_prev_reg   <= 1'b0;
      a_ack_reg      <= 1'b0;
      b_ack_reg      <= 1'b0;
      a_done_reg     <= 1'b0;
      b_done_reg     <= 1'b0;
      sd_lba_reg     <= 32'd0;
      sd_rd_reg      <= 1'b0;
      sd_wr_reg      <= 1'b0;
`ifdef SD_ARBITER_TIMEOUT_EN
      cnt_reg        <= '0;
      a_err_reg      <= 1'b0;
      b_err_reg      <= 1'b0;
`endif
    end else begin
      ack_prev_reg <= sd_ack;
      a_done_reg   <= 1'b0;
      b_done_reg   <= 1'b0;
`ifdef SD_ARBITER_TIMEOUT_EN
      a_err_reg    <= 1'b0;
      b_err_reg    <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (pend_a | pend_b) begin
            grant_reg  <= pick_b;
            sd_lba_reg <= pick_b ? b_lba : a_lba;
            sd_rd_reg  <= op_rd;
            sd_wr_reg  <= ~op_rd;
`ifdef SD_ARBITER_TIMEOUT_EN
            cnt_reg    <= '0;
`endif
            state_reg  <= ISSUE;
          end
        end
        ISSUE: begin
          if (ack_rise) begin
            sd_rd_reg <= 1'b0;
            sd_wr_reg <= 1'b0;
            a_ack_reg <= ~grant_reg;
            b_ack_reg <= grant_reg;
            state_reg <= XFER;
          end
`ifdef SD_ARBITER_TIMEOUT_EN
          else begin
            // Counter reaches all-ones on the same edge the abort is signalled.
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == TO_LAST) begin
              sd_rd_reg  <= 1'b0;
              sd_wr_reg  <= 1'b0;
              a_done_reg <= ~grant_reg;
              b_done_reg <= grant_reg;
              a_err_reg  <= ~grant_reg;
              b_err_reg  <= grant_reg;
              state_reg  <= DONE;
            end
          end
`endif
        end
        XFER: begin
          if (ack_fall) begin
            a_ack_reg  <= 1'b0;
            b_ack_reg  <= 1'b0;
            a_done_reg <= ~grant_reg;
            b_done_reg <= grant_reg;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          last_grant_reg <= grant_reg;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign a_ack       = a_ack_reg;
  assign b_ack       = b_ack_reg;
  assign a_done      = a_done_reg;
  assign b_done      = b_done_reg;
  assign sd_lba      = sd_lba_reg;
  assign sd_rd       = sd_rd_reg;
  assign sd_wr       = sd_wr_reg;
  // Byte traffic is routed combinationally, and only while the channel is in XFER.
  assign a_buff_wr   = in_xfer & ~grant_reg & sd_buff_wr;
  assign b_buff_wr   = in_xfer & grant_reg & sd_buff_wr;
  assign sd_buff_din = in_xfer ? (grant_reg ? b_buff_din : a_buff_din) : 8'd0;

endmodule
